// File: rtl/rtc_bus_sequencer.sv
// Arbiter and phase sequencer for the RTC multiplexed address/data bus.
// Grants one client, runs ADDR/GAP1/DATA/REC with registered strobes, returns read data and a done pulse.
module rtc_bus_sequencer #(
  parameter int N_CLIENTS = 4,
  parameter int DATA_W    = 8,
  parameter int T_PHASE   = 10,
  parameter int T_GAP     = 4,
  parameter int RR_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CLIENTS-1:0]          req,
  input  logic [N_CLIENTS-1:0]          wr,
  input  logic [N_CLIENTS*DATA_W-1:0]   addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   wdata,
  output logic [N_CLIENTS-1:0]          grant,
  output logic                          done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic                          cs_n,
  output logic                          rd_n,
  output logic                          wr_n,
  output logic                          ad,
  output logic [DATA_W-1:0]             bus_out,
  output logic                          bus_oe,
  input  logic [DATA_W-1:0]             bus_in
);

  localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [7:0] PHASE_M1 = 8'(T_PHASE - 1);
  localparam logic [7:0] GAP_M1   = 8'(T_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_REC} state_e;

  state_e                          state_q, state_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic [N_CLIENTS-1:0]            grant_q, grant_d;
  logic [PW-1:0]                   gidx_q, gidx_d, ptr_q, ptr_d;
  logic                            wr_lat_q, wr_lat_d;
  logic [DATA_W-1:0]               addr_lat_q, addr_lat_d, wdata_lat_q, wdata_lat_d;
  logic                            done_q, done_d;
  logic [DATA_W-1:0]               rdata_q, rdata_d;
  logic                            cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                            ad_q, ad_d, bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0]               bus_out_q, bus_out_d;

  logic [N_CLIENTS-1:0][DATA_W-1:0] addr_v, wdata_v;
  logic [N_CLIENTS-1:0]             win_oh;
  logic [PW-1:0]                    win_idx, lo_idx, hi_idx;
  logic                             hi_any;
  int                               base;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
    assign addr_v[i]  = addr[i*DATA_W +: DATA_W];
    assign wdata_v[i] = wdata[i*DATA_W +: DATA_W];
  end

  // Round-robin = lowest requester at/above ptr, else lowest overall (the wrap).
  always_comb begin
    base    = (RR_MODE != 0) ? int'(ptr_q) : 0;
    lo_idx  = '0;
    hi_idx  = '0;
    hi_any  = 1'b0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = PW'(i);
      if (req[i] && (i >= base)) begin
        hi_any = 1'b1;
        hi_idx = PW'(i);
      end
    end
    win_idx = hi_any ? hi_idx : lo_idx;
    win_oh  = '0;
    for (int i = 0; i < N_CLIENTS; i++) win_oh[i] = (PW'(i) == win_idx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      wr_lat_q    <= 1'b0;
      addr_lat_q  <= '0;
      wdata_lat_q <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ad_q        <= 1'b0;
      bus_oe_q    <= 1'b0;
      bus_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      wr_lat_q    <= wr_lat_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      ad_q        <= ad_d;
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    wr_lat_d    = wr_lat_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    if (state_q != S_IDLE && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    case (state_q)
      S_IDLE: if ((|req) && !done_q) begin
        state_d     = S_ADDR;
        cnt_d       = PHASE_M1;
        grant_d     = win_oh;
        gidx_d      = win_idx;
        wr_lat_d    = wr[win_idx];
        addr_lat_d  = addr_v[win_idx];
        wdata_lat_d = wdata_v[win_idx];
      end
      S_ADDR: if (cnt_q == 8'd0) begin
        state_d = S_GAP1;
        cnt_d   = GAP_M1;
      end
      S_GAP1: if (cnt_q == 8'd0) begin
        state_d = S_DATA;
        cnt_d   = PHASE_M1;
      end
      S_DATA: if (cnt_q == 8'd0) begin
        state_d = S_REC;
        cnt_d   = GAP_M1;
        if (!wr_lat_q) rdata_d = bus_in;
      end
      S_REC: if (cnt_q == 8'd0) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        grant_d = '0;
        ptr_d   = (gidx_q == PW'(N_CLIENTS - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode the next state so they can be registered without lagging a cycle.
  always_comb begin
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_d      = 1'b0;
    bus_oe_d  = 1'b0;
    bus_out_d = bus_out_q;
    case (state_d)
      S_ADDR: begin
        cs_n_d    = 1'b0;
        rd_n_d    = wr_lat_d;
        wr_n_d    = ~wr_lat_d;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_lat_d;
      end
      S_GAP1: bus_oe_d = wr_lat_d;
      S_DATA: begin
        cs_n_d   = 1'b0;
        ad_d     = 1'b1;
        rd_n_d   = wr_lat_d;
        wr_n_d   = ~wr_lat_d;
        bus_oe_d = wr_lat_d;
        if (wr_lat_d) bus_out_d = wdata_lat_d;
      end
      S_REC:   ad_d = 1'b1;
      default: ;
    endcase
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != S_IDLE);
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign ad      = ad_q;
  assign bus_oe  = bus_oe_q;
  assign bus_out = bus_out_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: fixed-priority and round-robin instances share stimulus and are
// checked every cycle against a transaction-level model, plus literal scenario checks.
module tb_rtc_bus_sequencer;
  localparam int N = 4, W = 8, TP = 4, TG = 2, L = 2*TP + 2*TG;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req, wr;
  logic [N*W-1:0] addr, wdata;
  logic [W-1:0] bus_in;
  logic [N-1:0] grant_f, grant_r;
  logic done_f, done_r, busy_f, busy_r, cs_n_f, cs_n_r, rd_n_f, rd_n_r, wr_n_f, wr_n_r;
  logic ad_f, ad_r, oe_f, oe_r;
  logic [W-1:0] rdata_f, rdata_r, bus_out_f, bus_out_r;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.N_CLIENTS(N), .DATA_W(W), .T_PHASE(TP), .T_GAP(TG), .RR_MODE(0)) dut_f (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .grant(grant_f), .done(done_f), .rdata(rdata_f), .busy(busy_f), .cs_n(cs_n_f),
    .rd_n(rd_n_f), .wr_n(wr_n_f), .ad(ad_f), .bus_out(bus_out_f), .bus_oe(oe_f), .bus_in(bus_in));

  rtc_bus_sequencer #(.N_CLIENTS(N), .DATA_W(W), .T_PHASE(TP), .T_GAP(TG), .RR_MODE(1)) dut_r (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .grant(grant_r), .done(done_r), .rdata(rdata_r), .busy(busy_r), .cs_n(cs_n_r),
    .rd_n(rd_n_r), .wr_n(wr_n_r), .ad(ad_r), .bus_out(bus_out_r), .bus_oe(oe_r), .bus_in(bus_in));

  int vecs = 0, miss = 0;

  // Model: index 0 = fixed priority, 1 = round-robin. m_t counts cycles into the transaction.
  bit       m_act[2], m_done[2], m_wr[2], m_bok[2];
  int       m_t[2], m_g[2], m_ptr[2];
  logic [7:0] m_a[2], m_d[2], m_rd[2];

  logic [3:0] gq_f[$], gq_r[$];
  int gaps_r[$];
  int idle_r = 0;
  logic [3:0] pg_f = '0, pg_r = '0;

  function automatic int pick(int m, logic [3:0] r);
    int s;
    s = (m == 1) ? m_ptr[m] : 0;
    for (int k = 0; k < N; k++) if (r[(s + k) % N] == 1'b1) return (s + k) % N;
    return 0;
  endfunction

  task automatic model_rst(input int m);
    m_act[m] = 0; m_done[m] = 0; m_wr[m] = 0; m_bok[m] = 1;
    m_t[m] = 0; m_g[m] = 0; m_ptr[m] = 0; m_a[m] = 0; m_d[m] = 0; m_rd[m] = 0;
  endtask

  task automatic model_step(input int m);
    bit pd;
    if (!reset) begin model_rst(m); return; end
    pd = m_done[m];
    m_done[m] = 0;
    if (m_act[m]) begin
      if (!m_wr[m] && m_t[m] == 2*TP + TG - 1) m_rd[m] = bus_in;
      m_t[m]++;
      if (m_t[m] == L) begin
        m_act[m] = 0; m_done[m] = 1; m_ptr[m] = (m_g[m] + 1) % N;
      end
    end else if (!pd && req != 0) begin
      m_g[m] = pick(m, req);
      m_act[m] = 1; m_t[m] = 0; m_bok[m] = 0;
      m_wr[m] = wr[m_g[m]];
      m_a[m] = addr[m_g[m]*W +: W];
      m_d[m] = wdata[m_g[m]*W +: W];
    end
  endtask

  task automatic model_exp(input int m, output logic [26:0] e, output logic [26:0] k);
    logic [3:0] g;
    logic cs, rn, wn, a, oe, am, bm;
    logic [7:0] bo;
    g = m_act[m] ? (4'b0001 << m_g[m]) : 4'b0000;
    cs = 1; rn = 1; wn = 1; a = 0; oe = 0; bo = 8'h00; am = 1; bm = m_bok[m];
    if (m_act[m]) begin
      if (m_t[m] < TP) begin
        cs = 0; oe = 1; bo = m_a[m]; bm = 1;
        if (m_wr[m]) wn = 0; else rn = 0;
      end else if (m_t[m] < TP + TG) begin
        oe = m_wr[m]; am = 0;
      end else if (m_t[m] < 2*TP + TG) begin
        cs = 0; a = 1; oe = m_wr[m];
        if (m_wr[m]) begin wn = 0; bo = m_d[m]; bm = 1; end else rn = 0;
      end else a = 1;
    end
    e = {g, m_done[m], m_rd[m], m_act[m], cs, rn, wn, a, oe, bo};
    k = {4'hF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, am, 1'b1, {8{bm}}};
  endtask

  task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] e, input logic [26:0] k);
    vecs++;
    if (((act ^ e) & k) != 27'd0) begin
      miss++;
      $display("FAIL %s t=%0t got=%h want=%h mask=%h", nm, $time, act, e, k);
    end
  endtask

  task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] e);
    vecs++;
    if (act !== e) begin
      miss++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, e);
    end
  endtask

  task automatic cyc();
    logic [26:0] e, k;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    model_exp(0, e, k);
    chk("fixed", {grant_f, done_f, rdata_f, busy_f, cs_n_f, rd_n_f, wr_n_f, ad_f, oe_f, bus_out_f}, e, k);
    model_exp(1, e, k);
    chk("rr", {grant_r, done_r, rdata_r, busy_r, cs_n_r, rd_n_r, wr_n_r, ad_r, oe_r, bus_out_r}, e, k);
    if (grant_f != 0 && pg_f == 0) gq_f.push_back(grant_f);
    if (grant_r != 0 && pg_r == 0) gq_r.push_back(grant_r);
    pg_f = grant_f;
    pg_r = grant_r;
    if (busy_r) begin
      if (idle_r > 0) gaps_r.push_back(idle_r);
      idle_r = 0;
    end else idle_r++;
  endtask

  task automatic set_client(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    wr[i] = w;
    addr[i*W +: W] = a;
    wdata[i*W +: W] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n, dc, rl, sz;
    bit ok;
    logic [3:0] exp5 [5];
    exp5 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0; bus_in = '0;
    model_rst(0); model_rst(1);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk1("rst_bus_out", bus_out_f, 8'h00);
    chk1("rst_strobes", {cs_n_f, rd_n_f, wr_n_f, ad_f, oe_f}, 5'b11100);

    // Write: client 2, addr 0x21, data 0x5A
    set_client(2, 1'b1, 8'h21, 8'h5A);
    req = 4'b0100;
    cyc();
    chk1("wr_grant", grant_f, 4'b0100);
    chk1("wr_addr_bus", bus_out_f, 8'h21);
    chk1("wr_addr_strobes", {cs_n_f, wr_n_f, rd_n_f, ad_f}, 4'b0010);
    n = 1; dc = 0; ok = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (done_f) begin ok = 1; break; end
      if (busy_f) n++;
      if (ad_f && !wr_n_f && !cs_n_f && bus_out_f == 8'h5A) dc++;
    end
    chk1("wr_done_seen", 32'(ok), 32'd1);
    chk1("wr_busy_len", n, 12);
    chk1("wr_data_cycles", dc, 4);
    req = '0;

    // Read: client 0, addr 0x23, bus returns 0x37
    set_client(0, 1'b0, 8'h23, 8'h00);
    bus_in = 8'h37;
    req = 4'b0001;
    rl = 0; ok = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (done_f) begin ok = 1; break; end
      if (!rd_n_f) rl++;
    end
    chk1("rd_done_seen", 32'(ok), 32'd1);
    chk1("rd_strobe_cycles", rl, 8);
    chk1("rd_rdata", rdata_f, 8'h37);
    req = '0;

    // Fixed priority with clients 1 and 3 requesting
    wr = 4'b1010;
    req = 4'b1010;
    gq_f.delete();
    for (int c = 0; c < 3*(L+2) + 8 && gq_f.size() < 3; c++) cyc();
    chk1("fp_count", 32'(gq_f.size() >= 3), 32'd1);
    foreach (gq_f[i]) chk1("fp_grant", gq_f[i], 4'b0010);

    // Reset in the middle of ADDR
    req = 4'hF;
    sz = gq_f.size();
    for (int c = 0; c < 2*(L+2) && gq_f.size() == sz; c++) cyc();
    chk1("rst_grant_seen", 32'(gq_f.size() > sz), 32'd1);
    cyc();
    reset = 1'b0;
    #1;
    chk1("rst_mid_strobes", {cs_n_f, rd_n_f, wr_n_f, oe_f}, 4'b1110);
    chk1("rst_mid_grant", {grant_f, grant_r}, 8'h00);
    chk1("rst_mid_busy_done", {busy_f, done_f}, 2'b00);
    model_rst(0); model_rst(1);
    cyc(); cyc();
    reset = 1'b1;

    // Round-robin with all four requesting
    gq_f.delete(); gq_r.delete(); gaps_r.delete(); idle_r = 0;
    for (int c = 0; c < 5*(L+2) + 10 && gq_r.size() < 5; c++) cyc();
    chk1("rr_count", 32'(gq_r.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) if (i < gq_r.size()) chk1("rr_order", gq_r[i], exp5[i]);
    foreach (gq_f[i]) chk1("fp_all_grant", gq_f[i], 4'b0001);
    chk1("rr_gaps", 32'(gaps_r.size() >= 4), 32'd1);
    for (int i = 1; i < 4; i++) if (i < gaps_r.size()) chk1("rr_gap_len", gaps_r[i], 2);

    // Client 1 drops req and changes addr/wr mid DATA
    req = '0;
    for (int c = 0; c < 2*(L+2) && (busy_f || busy_r || done_f || done_r); c++) cyc();
    set_client(1, 1'b1, 8'h44, 8'hC3);
    req = 4'b0010;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (done_f) begin ok = 1; break; end
      if (m_act[0] && m_t[0] >= TP + TG) begin
        req = '0; addr[15:8] = 8'h99; wr[1] = 1'b0;
      end
    end
    chk1("chg_done_seen", 32'(ok), 32'd1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk1("chg_no_regrant", grant_f, 4'b0000);
    end

    // Randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      wr = 4'($urandom_range(0, 15));
      addr = $urandom;
      wdata = $urandom;
      bus_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) reset = 1'b0;
      cyc();
      reset = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised arbiter and bus sequencer for the RTC's multiplexed address/data bus. It accepts single-register read or write requests from N client state machines (init, read, write, crono, …) and grants one client at a time, either by fixed priority or by round-robin. It then runs the address phase, gap, data phase and recovery with programmable phase lengths, and returns read data plus a one-cycle completion pulse. It replaces the ad-hoc combinational data/address muxing and machine-select logic at the top level; the top level converts `bus_out`/`bus_oe`/`bus_in` to the inout pin.

## Interface
- `N_CLIENTS`, default 4: number of requesting clients, from 1 to 8.
- `DATA_W`, default 8: width of the address/data bus.
- `T_PHASE`, default 10: cycles each strobe is held low in the address and data phases, from 1 to 255.
- `T_GAP`, default 4: cycles all strobes are high after each phase, from 1 to 255.
- `RR_MODE`, default 0: 0 selects fixed priority (client 0 highest); 1 selects round-robin.
- `clk` in, 1 bit: system clock; all logic on the rising edge.
- `reset` in, 1 bit: asynchronous, active-low reset.
- `req` in, N_CLIENTS bits: request, one bit per client; held until `done` while the client is granted.
- `wr` in, N_CLIENTS bits: 1 = write, 0 = read, per client.
- `addr` in, N_CLIENTS*DATA_W bits: flattened register addresses; client i uses bits [i*DATA_W +: DATA_W].
- `wdata` in, N_CLIENTS*DATA_W bits: flattened write data, same packing as `addr`.
- `grant` out, N_CLIENTS bits: one-hot, registered; high from the first ADDR cycle through the last REC cycle.
- `done` out, 1 bit: one-cycle pulse when the transaction completes.
- `rdata` out, DATA_W bits: last read data; holds its value until the next read completes.
- `busy` out, 1 bit: high whenever the state is not IDLE.
- `cs_n`, `rd_n`, `wr_n` out, 1 bit each: active-low RTC chip-select, read and write strobes.
- `ad` out, 1 bit: 0 = address phase, 1 = data phase.
- `bus_out` out, DATA_W bits: value driven onto the bus.
- `bus_oe` out, 1 bit: bus drive enable.
- `bus_in` in, DATA_W bits: value read from the bus pin.

## Operation
- **States:** IDLE → ADDR → GAP1 → DATA → REC → IDLE.
- **Phase counter:** a down-counter, 8 bits wide, loaded with (length − 1) on entry to each phase. The state advances when the counter reaches 0 (ADDR and DATA use T_PHASE; GAP1 and REC use T_GAP).
- **IDLE:**
  - Outputs: `cs_n`=`rd_n`=`wr_n`=1, `ad`=0, `bus_oe`=0.
  - If any `req` bit is high and `done` is low, the winner is chosen. At the next edge the FSM loads `grant`, latches that client's `wr`, `addr` and `wdata`, and enters ADDR.
  - Requests are ignored in the cycle `done` is high. This gives a turnaround cycle, so a client can drop `req`.
- **Winner selection:**
  - Fixed priority (`RR_MODE`=0): the lowest-index requester wins.
  - Round-robin (`RR_MODE`=1): the first requester found at or above pointer `ptr`, wrapping modulo N_CLIENTS.
  - On each `done`, `ptr` becomes (granted index + 1) mod N. The reset value of `ptr` is 0.
- **ADDR:**
  - `cs_n`=0, `ad`=0, `bus_out`=latched address, `bus_oe`=1.
  - `wr_n`=0 for a write, `rd_n`=0 for a read.
- **GAP1:** `cs_n`=`rd_n`=`wr_n`=1. `bus_oe` stays 1 for a write and is 0 for a read.
- **DATA, write:** `cs_n`=0, `ad`=1, `wr_n`=0, `bus_out`=latched data, `bus_oe`=1.
- **DATA, read:** `cs_n`=0, `ad`=1, `rd_n`=0, `bus_oe`=0. `bus_in` is registered into `rdata` at the edge that leaves DATA.
- **REC:**
  - All strobes are high, `ad`=1, `bus_oe`=0.
  - At the edge leaving REC: `done`=1 for one cycle, `grant` clears, and the FSM returns to IDLE.
- **Request changes mid-transaction:** once granted, the transaction always runs to completion. Changes to `req`, `addr`, `wdata` or `wr` have no effect.
- **Strobe glitches:** all bus outputs (strobes, `ad`, `bus_out`, `bus_oe`) are registered, so they are glitch-free.
- **Reset (`reset`=0) at any time:**
  - State = IDLE; `grant`=0, `done`=0, `busy`=0, `rdata`=0, `ptr`=0.
  - `cs_n`=`rd_n`=`wr_n`=1, `ad`=0, `bus_out`=0, `bus_oe`=0.
  - Any transaction in progress is aborted without asserting `done`.

## Timing
- **Latency:** from the first IDLE cycle with `req` high, `grant` rises at the next edge.
- **Transaction length:** `busy` spans 2·T_PHASE + 2·T_GAP cycles. `done` appears in the first IDLE cycle afterwards.
- **Example:** with T_PHASE=4 and T_GAP=2, a transaction takes 12 busy cycles plus the `done` cycle.
- **Back-to-back transactions:** at most one transaction every 2·T_PHASE + 2·T_GAP + 2 cycles.
- **Read sampling:** data is captured on the last DATA cycle, with `rd_n` low for T_PHASE cycles before capture.
- **Single-client case:** N_CLIENTS=1 is legal. Arbitration degenerates, and `ptr` stays 0.

## Test plan
All scenarios use N_CLIENTS=4, T_PHASE=4, T_GAP=2.
1. **Reset:** `reset` low mid-ADDR → the same cycle shows strobes=1, `bus_oe`=0, `grant`=0, `busy`=0; no `done`.
2. **Write:** client 2 writes address 0x21 with data 0x5A → `grant`=0100. Then:
   - 4 cycles of `cs_n`/`wr_n`=0 with `ad`=0 and `bus_out`=0x21;
   - 2 gap cycles;
   - 4 cycles of `wr_n`=0 with `ad`=1 and `bus_out`=0x5A;
   - 2 REC cycles, then `done`=1.
3. **Read:** client 0 reads address 0x23 while the bench drives `bus_in`=0x37 during DATA → `rd_n` is low in both phases, `bus_oe` is 0 in DATA, `rdata`=0x37 when `done` rises.
4. **Fixed priority:** `req`=1010 held continuously → `grant` order is 0010, 0010, … Client 3 is never served while client 1 keeps requesting.
5. **Round-robin** (`RR_MODE`=1): `req`=1111 held → `grant` order is 0001, 0010, 0100, 1000, 0001, with a gap of 2 cycles between `busy` periods.
6. **Request changes mid-transaction:** client 1 drops `req` and changes `addr` during DATA → the transaction completes unchanged with `done` pulsed, and no new grant is issued for client 1.
